// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative radix-2 multiply/divide unit with its own HI/LO pair.
// MULT/MULTU/DIV/DIVU take WIDTH+1 busy cycles; MTHI/MTLO complete on the
// accept edge. Signed operations run on magnitudes and fix the sign at the end.
`timescale 1ns/1ps
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting out / quotient in}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;     // product / quotient must be negated
  logic               rneg_q, rneg_d;   // remainder must be negated
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo_neg, rem_neg;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag     = b_neg ? (~b + WIDTH'(1)) : b;

  // One shift-add step: add multiplicand when the current multiplier LSB is set.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  // One restoring step: trial-subtract divisor from {remainder, next dividend bit};
  // the extra top bit is the borrow so a divisor of zero never looks like a borrow.
  assign div_trial = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opb_q};

  assign prod_neg  = ~acc_q + (2*WIDTH)'(1);
  assign quo_neg   = ~acc_q[WIDTH-1:0] + WIDTH'(1);
  assign rem_neg   = ~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1);

  // Next-state logic: accept, iterate, sign-fix and write back, with flush abort.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d  = S_CALC;
              cnt_d    = CW'(WIDTH-1);
              is_div_d = op[1];
              neg_d    = a_neg ^ b_neg;
              rneg_d   = a_neg;
              div0_d   = (b == '0);
              if (op[1]) begin
                acc_d = {{WIDTH{1'b0}}, a_mag};
                opb_d = b_mag;
              end else begin
                acc_d = {{WIDTH{1'b0}}, b_mag};
                opb_d = a_mag;
              end
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            if (!div_trial[WIDTH+1]) begin
              acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Dividing by zero leaves |a| as remainder, so the remainder sign
            // fix restores the original dividend; only LO needs overriding.
            lo_d = div0_q ? '1 : (neg_q ? quo_neg : acc_q[WIDTH-1:0]);
            hi_d = rneg_q ? rem_neg : acc_q[2*WIDTH-1:WIDTH];
          end else begin
            {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed testbench for muldiv_hilo (WIDTH=32 main instance, WIDTH=8 second instance).
`timescale 1ns/1ps
module tb_muldiv_hilo;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  logic         start8 = 1'b0;
  logic [2:0]   op8 = 3'd0;
  logic [7:0]   a8 = '0;
  logic [7:0]   b8 = '0;
  logic         flush8 = 1'b0;
  logic         busy8, done8;
  logic [7:0]   hi8, lo8;

  int checks = 0;
  int failures = 0;

  muldiv_hilo #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_hilo #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  // Issue one op, scramble operands after accept, observe WIDTH+5 cycles.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int nb, output int nd, output int dk,
                        output logic [W-1:0] mh, output logic [W-1:0] ml);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEADBEEF; b = 32'h00000003;
    nb = 0; nd = 0; dk = -1; mh = '0; ml = '0;
    for (int k = 0; k < W + 5; k++) begin
      if (busy) nb++;
      if (done) begin nd++; dk = k; end
      if (k == 10) begin mh = hi; ml = lo; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #12;
    checks++; if (hi !== '0)    begin failures++; $display("FAIL reset_hi: got %h exp 0", hi); end
    checks++; if (lo !== '0)    begin failures++; $display("FAIL reset_lo: got %h exp 0", lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b exp 0", done); end
    @(negedge clk); reset_n = 1'b1;
    $display("reset: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
  endtask

  // Shared checks for one arithmetic vector.
  task automatic check_vec(input string nm, input int nb, input int nd, input int dk,
                           input logic [W-1:0] mh, input logic [W-1:0] ml,
                           input logic [W-1:0] ph, input logic [W-1:0] pl,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
    checks++; if (nb != W + 1) begin failures++; $display("FAIL %s_busy_cycles: got %0d exp %0d", nm, nb, W + 1); end
    checks++; if (nd != 1)     begin failures++; $display("FAIL %s_done_count: got %0d exp 1", nm, nd); end
    checks++; if (dk != W + 1) begin failures++; $display("FAIL %s_done_cycle: got %0d exp %0d", nm, dk, W + 1); end
    checks++; if (mh !== ph || ml !== pl) begin failures++; $display("FAIL %s_hold: got %h/%h exp %h/%h", nm, mh, ml, ph, pl); end
    checks++; if (hi !== eh)   begin failures++; $display("FAIL %s_hi: got %h exp %h", nm, hi, eh); end
    checks++; if (lo !== el)   begin failures++; $display("FAIL %s_lo: got %h exp %h", nm, lo, el); end
    $display("%s: hi=%h lo=%h busy_cycles=%0d done_at=%0d", nm, hi, lo, nb, dk);
  endtask

  task automatic test_multiply();
    logic [2:0]   t_op [3];
    logic [W-1:0] t_a [3], t_b [3], t_h [3], t_l [3];
    logic [W-1:0] ph, pl, mh, ml;
    int nb, nd, dk;
    t_op = '{3'd0, 3'd1, 3'd0};
    t_a  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    t_b  = '{32'h00000007, 32'hFFFFFFFF, 32'h80000000};
    t_h  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h40000000};
    t_l  = '{32'hFFFFFFEB, 32'h00000001, 32'h00000000};
    ph = '0; pl = '0;
    for (int i = 0; i < 3; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], nb, nd, dk, mh, ml);
      check_vec($sformatf("mul%0d", i), nb, nd, dk, mh, ml, ph, pl, t_h[i], t_l[i]);
      ph = t_h[i]; pl = t_l[i];
    end
  endtask

  task automatic test_divide();
    logic [2:0]   t_op [6];
    logic [W-1:0] t_a [6], t_b [6], t_h [6], t_l [6];
    logic [W-1:0] ph, pl, mh, ml;
    int nb, nd, dk;
    t_op = '{3'd3, 3'd2, 3'd2, 3'd2, 3'd3, 3'd2};
    t_a  = '{32'd100, 32'hFFFFFFF9, 32'd7,        32'h80000000, 32'h00001234, 32'hFFFFFFF9};
    t_b  = '{32'd7,   32'd2,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    t_h  = '{32'd2,   32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h00001234, 32'hFFFFFFF9};
    t_l  = '{32'd14,  32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    ph = 32'h40000000; pl = '0;
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], nb, nd, dk, mh, ml);
      check_vec($sformatf("div%0d", i), nb, nd, dk, mh, ml, ph, pl, t_h[i], t_l[i]);
      ph = t_h[i]; pl = t_l[i];
    end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hA5A5A5A5;
    @(posedge clk); #1;
    checks++; if (hi !== 32'hA5A5A5A5) begin failures++; $display("FAIL mthi_hi: got %h exp a5a5a5a5", hi); end
    checks++; if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL mthi_lo: got %h exp ffffffff", lo); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL mthi_busy: got %b exp 0", busy); end
    op = 3'd5; a = 32'h5A5A5A5A;
    @(posedge clk); #1;
    checks++; if (lo !== 32'h5A5A5A5A) begin failures++; $display("FAIL mtlo_lo: got %h exp 5a5a5a5a", lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mtlo_busy_done: got %b/%b exp 0/0", busy, done); end
    op = 3'd6; a = 32'h12345678; b = 32'h9;
    @(posedge clk); #1;
    op = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (hi !== 32'hA5A5A5A5 || lo !== 32'h5A5A5A5A) begin failures++; $display("FAIL reserved_hilo: got %h/%h exp a5a5a5a5/5a5a5a5a", hi, lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reserved_busy: got %b exp 0", busy); end
    $display("mthi_mtlo: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_stall_flush();
    int nb, nd, dk;
    logic [W-1:0] mh, ml;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h11;
    @(posedge clk); #1;
    op = 3'd5; a = 32'h22;
    @(posedge clk); #1;
    op = 3'd1; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;                    // accept edge E0
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    start = 1'b1; op = 3'd4; a = 32'h99;   // must be ignored while busy
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (hi !== 32'h11)  begin failures++; $display("FAIL busy_start_hi: got %h exp 11", hi); end
    checks++; if (busy !== 1'b1)  begin failures++; $display("FAIL busy_start_busy: got %b exp 1", busy); end
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL flush_busy: got %b exp 0", busy); end
    checks++; if (hi !== 32'h11 || lo !== 32'h22) begin failures++; $display("FAIL flush_hilo: got %h/%h exp 11/22", hi, lo); end
    nb = 0; nd = 0;
    for (int k = 0; k < W + 5; k++) begin
      if (busy) nb++;
      if (done) nd++;
      @(posedge clk); #1;
    end
    checks++; if (nb != 0 || nd != 0) begin failures++; $display("FAIL flush_after: got busy=%0d done=%0d exp 0/0", nb, nd); end
    flush = 1'b1; start = 1'b1; op = 3'd4; a = 32'h77;
    @(posedge clk); #1;
    checks++; if (hi !== 32'h11) begin failures++; $display("FAIL flush_start_mthi: got %h exp 11", hi); end
    op = 3'd0; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_start_mult: got %b exp 0", busy); end
    flush = 1'b0; start = 1'b0;
    run_op(3'd1, 32'd3, 32'd5, nb, nd, dk, mh, ml);
    check_vec("multu_after_flush", nb, nd, dk, mh, ml, 32'h11, 32'h22, 32'h0, 32'd15);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (W + 1) begin @(posedge clk); #1; end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_done1: got done=%b busy=%b exp 1/0", done, busy); end
    checks++; if (hi !== 32'd2 || lo !== 32'd14) begin failures++; $display("FAIL b2b_res1: got %h/%h exp 2/e", hi, lo); end
    start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_accept: got busy=%b done=%b exp 1/0", busy, done); end
    repeat (W + 1) begin @(posedge clk); #1; end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done2: got %b exp 1", done); end
    checks++; if (hi !== 32'd0 || lo !== 32'd42) begin failures++; $display("FAIL b2b_res2: got %h/%h exp 0/2a", hi, lo); end
    $display("back_to_back: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_reset_mid_op();
    int nb, nd, dk;
    logic [W-1:0] mh, ml;
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    checks++; if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL midreset_hilo: got %h/%h exp 0/0", hi, lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midreset_busy_done: got %b/%b exp 0/0", busy, done); end
    @(negedge clk); reset_n = 1'b1;
    run_op(3'd0, 32'hFFFFFFFD, 32'd7, nb, nd, dk, mh, ml);
    check_vec("mult_after_reset", nb, nd, dk, mh, ml, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB);
  endtask

  task automatic test_width8();
    int nb, nd, dk;
    @(negedge clk);
    start8 = 1'b1; op8 = 3'd0; a8 = 8'hFD; b8 = 8'h07;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h55; b8 = 8'h02;
    nb = 0; nd = 0; dk = -1;
    for (int k = 0; k < 13; k++) begin
      if (busy8) nb++;
      if (done8) begin nd++; dk = k; end
      @(posedge clk); #1;
    end
    checks++; if (nb != 9)  begin failures++; $display("FAIL w8_busy_cycles: got %0d exp 9", nb); end
    checks++; if (nd != 1 || dk != 9) begin failures++; $display("FAIL w8_done: got count=%0d at=%0d exp 1 at 9", nd, dk); end
    checks++; if (hi8 !== 8'hFF || lo8 !== 8'hEB) begin failures++; $display("FAIL w8_result: got %h/%h exp ff/eb", hi8, lo8); end
    $display("width8: hi=%h lo=%h busy_cycles=%0d", hi8, lo8, nb);
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_mthi_mtlo();
    test_stall_flush();
    test_back_to_back();
    test_reset_mid_op();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
